// File: rtl/line_buffer_pp.sv
// Ping-pong line buffer: NUM_BANK banks of LINE lines, with luma at full rate and chroma decimated.
// Optional sticky overflow/underflow flag on o_err when LINE_BUFFER_PP_ERR_EN is defined.
module line_buffer_pp #(
    parameter int COLOR_PRECISION = 8,
    parameter int MAX_HRES        = 480,
    parameter int LINE            = 16,
    parameter int NUM_CH          = 3,
    parameter int NUM_BANK        = 2,
    parameter int C_XO_SUBSAMPLE  = 2,
    parameter int C_YO_SUBSAMPLE  = 2,
    localparam int XW = $clog2(MAX_HRES),
    localparam int BW = $clog2(NUM_BANK + 1),
    localparam int DW = NUM_CH * COLOR_PRECISION
) (
    input  logic          i_sysclk,
    input  logic          i_arstn,
    input  logic [XW-1:0] i_hres,
    input  logic          i_we,
    input  logic [DW-1:0] i_wd,
    output logic          o_full,
    input  logic          i_re,
    output logic [DW-1:0] o_rd,
    output logic          o_rd_valid,
    output logic          o_nempty,
    output logic [BW-1:0] o_bank_cnt,
    output logic          o_err
);
    localparam int CP     = COLOR_PRECISION;
    localparam int YW     = $clog2(LINE);
    localparam int BKW    = $clog2(NUM_BANK);
    localparam int LAW    = BKW + YW + XW;
    localparam int LDEPTH = 1 << LAW;
    localparam int CLINES = LINE / C_YO_SUBSAMPLE;
    localparam int CXN    = (1 << XW) / C_XO_SUBSAMPLE;
    localparam int CDEPTH = NUM_BANK * CLINES * CXN;
    localparam int CAW    = $clog2(CDEPTH);

    logic [1:0]     rst_sync_reg;
    logic           run;
    logic [BKW-1:0] wbank_reg, rbank_reg;
    logic [YW-1:0]  wy_reg, ry_reg;
    logic [XW-1:0]  wx_reg, rx_reg, whres_reg, rhres_reg;
    logic [BW-1:0]  bank_cnt_reg, bank_cnt_next;
    logic           full_reg, nempty_reg, rd_valid_reg;
    logic           wr_ok, rd_ok, wstart, rstart, wline_end, rline_end, fill, free;
    logic [XW-1:0]  whres_eff, rhres_eff;

    // Reset release is re-timed so the pointers leave reset cleanly; assertion stays asynchronous.
    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) rst_sync_reg <= 2'b00;
        else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign run = rst_sync_reg[1];

    assign wr_ok     = i_we & ~full_reg & run;
    assign rd_ok     = i_re & nempty_reg & run;
    // Line width is captured on the first pixel of each bank fill/drain.
    assign wstart    = (wx_reg == '0) && (wy_reg == '0);
    assign rstart    = (rx_reg == '0) && (ry_reg == '0);
    assign whres_eff = wstart ? i_hres : whres_reg;
    assign rhres_eff = rstart ? i_hres : rhres_reg;
    assign wline_end = (wx_reg == whres_eff);
    assign rline_end = (rx_reg == rhres_eff);
    assign fill      = wr_ok & wline_end & (wy_reg == YW'(LINE - 1));
    assign free      = rd_ok & rline_end & (ry_reg == YW'(LINE - 1));

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            wbank_reg <= '0;
            wy_reg    <= '0;
            wx_reg    <= '0;
            whres_reg <= '0;
        end else if (wr_ok) begin
            if (wstart) whres_reg <= i_hres;
            if (wline_end) begin
                wx_reg <= '0;
                if (wy_reg == YW'(LINE - 1)) begin
                    wy_reg    <= '0;
                    wbank_reg <= wbank_reg + BKW'(1);
                end else begin
                    wy_reg <= wy_reg + YW'(1);
                end
            end else begin
                wx_reg <= wx_reg + XW'(1);
            end
        end
    end

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            rbank_reg <= '0;
            ry_reg    <= '0;
            rx_reg    <= '0;
            rhres_reg <= '0;
        end else if (rd_ok) begin
            if (rstart) rhres_reg <= i_hres;
            if (rline_end) begin
                rx_reg <= '0;
                if (ry_reg == YW'(LINE - 1)) begin
                    ry_reg    <= '0;
                    rbank_reg <= rbank_reg + BKW'(1);
                end else begin
                    ry_reg <= ry_reg + YW'(1);
                end
            end else begin
                rx_reg <= rx_reg + XW'(1);
            end
        end
    end

    always_comb begin
        bank_cnt_next = bank_cnt_reg;
        if (fill && !free)      bank_cnt_next = bank_cnt_reg + BW'(1);
        else if (free && !fill) bank_cnt_next = bank_cnt_reg - BW'(1);
    end

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            bank_cnt_reg <= '0;
            full_reg     <= 1'b0;
            nempty_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            bank_cnt_reg <= bank_cnt_next;
            full_reg     <= (bank_cnt_next == BW'(NUM_BANK));
            nempty_reg   <= (bank_cnt_next != '0);
            rd_valid_reg <= rd_ok;
        end
    end

    assign o_bank_cnt = bank_cnt_reg;
    assign o_full     = full_reg;
    assign o_nempty   = nempty_reg;
    assign o_rd_valid = rd_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CP-1:0] rd_q_reg;
            if (gi == 0) begin : g_luma
                logic [CP-1:0]  mem [LDEPTH];
                logic [LAW-1:0] waddr, raddr;
                assign waddr = {wbank_reg, wy_reg, wx_reg};
                assign raddr = {rbank_reg, ry_reg, rx_reg};
                always_ff @(posedge i_sysclk) begin
                    if (wr_ok) mem[waddr] <= i_wd[0 +: CP];
                end
                always_ff @(posedge i_sysclk or negedge i_arstn) begin
                    if (!i_arstn)   rd_q_reg <= '0;
                    else if (rd_ok) rd_q_reg <= mem[raddr];
                end
            end else begin : g_chroma
                logic [CP-1:0]  mem [CDEPTH];
                logic [CAW-1:0] waddr, raddr;
                logic           cwe;
                // Linear address so that a decimated y field of zero width still works.
                assign waddr = CAW'(wbank_reg) * CAW'(CLINES * CXN)
                             + CAW'(wy_reg >> (C_YO_SUBSAMPLE - 1)) * CAW'(CXN)
                             + CAW'(wx_reg >> (C_XO_SUBSAMPLE - 1));
                assign raddr = CAW'(rbank_reg) * CAW'(CLINES * CXN)
                             + CAW'(ry_reg >> (C_YO_SUBSAMPLE - 1)) * CAW'(CXN)
                             + CAW'(rx_reg >> (C_XO_SUBSAMPLE - 1));
                assign cwe = wr_ok & ((C_XO_SUBSAMPLE == 1) | ~wx_reg[0])
                                   & ((C_YO_SUBSAMPLE == 1) | ~wy_reg[0]);
                always_ff @(posedge i_sysclk) begin
                    if (cwe) mem[waddr] <= i_wd[gi*CP +: CP];
                end
                always_ff @(posedge i_sysclk or negedge i_arstn) begin
                    if (!i_arstn)   rd_q_reg <= '0;
                    else if (rd_ok) rd_q_reg <= mem[raddr];
                end
            end
            assign o_rd[gi*CP +: CP] = rd_q_reg;
        end
    endgenerate

`ifdef LINE_BUFFER_PP_ERR_EN
    logic err_reg;
    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) err_reg <= 1'b0;
        else if ((i_we & full_reg) | (i_re & ~nempty_reg)) err_reg <= 1'b1;
    end
    assign o_err = err_reg;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_pp.sv
// Directed bench for line_buffer_pp: LINE=2, two banks, 4-pixel lines, luma + one 2x2-decimated chroma.
module tb_line_buffer_pp;
    localparam int CP   = 8;
    localparam int MAXH = 4;
    localparam int LN   = 2;
    localparam int NCH  = 2;
    localparam int NB   = 2;
    localparam int XW   = $clog2(MAXH);
    localparam int BW   = $clog2(NB + 1);
`ifdef LINE_BUFFER_PP_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic              i_sysclk, i_arstn, i_we, i_re;
    logic [XW-1:0]     i_hres;
    logic [NCH*CP-1:0] i_wd, o_rd;
    logic              o_full, o_rd_valid, o_nempty, o_err;
    logic [BW-1:0]     o_bank_cnt;

    line_buffer_pp #(
        .COLOR_PRECISION(CP), .MAX_HRES(MAXH), .LINE(LN), .NUM_CH(NCH), .NUM_BANK(NB),
        .C_XO_SUBSAMPLE(2), .C_YO_SUBSAMPLE(2)
    ) dut (
        .i_sysclk(i_sysclk), .i_arstn(i_arstn), .i_hres(i_hres), .i_we(i_we), .i_wd(i_wd),
        .o_full(o_full), .i_re(i_re), .o_rd(o_rd), .o_rd_valid(o_rd_valid),
        .o_nempty(o_nempty), .o_bank_cnt(o_bank_cnt), .o_err(o_err)
    );

    initial i_sysclk = 1'b0;
    always #5 i_sysclk = ~i_sysclk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       we, re;
        logic [7:0] lv, cv;
        logic       vld;
        logic [7:0] el, ec;
        logic [1:0] cnt;
        logic       full, ne;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock with the given strobes; inputs change 1 time unit after the edge.
    task automatic cyc(input logic we, input logic re, input logic [7:0] lv, input logic [7:0] cv);
        i_we = we;
        i_re = re;
        i_wd = {cv, lv};
        @(posedge i_sysclk);
        #1;
        i_we = 1'b0;
        i_re = 1'b0;
    endtask

    task automatic wr(input logic [7:0] lv);
        cyc(1'b1, 1'b0, lv, 8'd0);
    endtask

    task automatic rd_exp(input string nm, input logic [7:0] el);
        cyc(1'b0, 1'b1, 8'd0, 8'd0);
        chk({nm, "_vld"}, {31'd0, o_rd_valid}, 32'd1);
        chk(nm, {24'd0, o_rd[7:0]}, {24'd0, el});
    endtask

    task automatic do_reset();
        i_arstn = 1'b0;
        #2;
        i_arstn = 1'b1;
        cyc(1'b0, 1'b0, 8'd0, 8'd0);
        cyc(1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we    re    lv     cv     vld   el     ec     cnt   full  ne
        vecs[0]  = '{1'b1, 1'b0, 8'd0, 8'd0,  1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'd1, 8'd1,  1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'd2, 8'd2,  1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'd3, 8'd3,  1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'd4, 8'd10, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'd5, 8'd11, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'd6, 8'd12, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'd7, 8'd13, 1'b0, 8'd0, 8'd0, 2'd1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'd0, 8'd0,  1'b1, 8'd0, 8'd0, 2'd1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'd0, 8'd0,  1'b1, 8'd1, 8'd0, 2'd1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 8'd0, 8'd0,  1'b1, 8'd2, 8'd2, 2'd1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'd0, 8'd0,  1'b1, 8'd3, 8'd2, 2'd1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'd0, 8'd0,  1'b1, 8'd4, 8'd0, 2'd1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 8'd0, 8'd0,  1'b1, 8'd5, 8'd0, 2'd1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 8'd0, 8'd0,  1'b1, 8'd6, 8'd2, 2'd1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 8'd0, 8'd0,  1'b1, 8'd7, 8'd2, 2'd0, 1'b0, 1'b0};

        i_arstn = 1'b0;
        i_we    = 1'b0;
        i_re    = 1'b0;
        i_wd    = '0;
        i_hres  = XW'(3);
        repeat (2) @(posedge i_sysclk);
        #1;
        chk("rst_cnt",    {30'd0, o_bank_cnt}, 32'd0);
        chk("rst_full",   {31'd0, o_full},     32'd0);
        chk("rst_nempty", {31'd0, o_nempty},   32'd0);
        chk("rst_valid",  {31'd0, o_rd_valid}, 32'd0);
        chk("rst_rd",     {16'd0, o_rd},       32'd0);
        chk("rst_err",    {31'd0, o_err},      32'd0);
        i_arstn = 1'b1;
        cyc(1'b0, 1'b0, 8'd0, 8'd0);
        cyc(1'b0, 1'b0, 8'd0, 8'd0);

        // Fill one bank then drain it; chroma replicated over 2x2 blocks.
        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].we, vecs[i].re, vecs[i].lv, vecs[i].cv);
            $display("[TB] vec %0d we=%0b re=%0b vld=%0b rd=%04h cnt=%0d", i, vecs[i].we, vecs[i].re,
                     o_rd_valid, o_rd, o_bank_cnt);
            chk($sformatf("vec%0d_vld", i),  {31'd0, o_rd_valid}, {31'd0, vecs[i].vld});
            chk($sformatf("vec%0d_cnt", i),  {30'd0, o_bank_cnt}, {30'd0, vecs[i].cnt});
            chk($sformatf("vec%0d_full", i), {31'd0, o_full},     {31'd0, vecs[i].full});
            chk($sformatf("vec%0d_ne", i),   {31'd0, o_nempty},   {31'd0, vecs[i].ne});
            if (vecs[i].vld) begin
                chk($sformatf("vec%0d_luma", i),   {24'd0, o_rd[7:0]},  {24'd0, vecs[i].el});
                chk($sformatf("vec%0d_chroma", i), {24'd0, o_rd[15:8]}, {24'd0, vecs[i].ec});
            end
        end
        cyc(1'b0, 1'b0, 8'd0, 8'd0);
        chk("hold_valid", {31'd0, o_rd_valid}, 32'd0);
        chk("hold_rd",    {16'd0, o_rd},       32'h0207);

        // Overflow, then a write colliding with the freeing read while full.
        do_reset();
        for (int n = 0; n < 16; n++) wr(8'(n));
        chk("ovf_cnt",  {30'd0, o_bank_cnt}, 32'd2);
        chk("ovf_full", {31'd0, o_full},     32'd1);
        wr(8'd99);
        $display("[TB] 17th write: cnt=%0d full=%0b err=%0b", o_bank_cnt, o_full, o_err);
        chk("ovf_cnt2", {30'd0, o_bank_cnt}, 32'd2);
        chk("ovf_err",  {31'd0, o_err},      {31'd0, ERR_EN});
        for (int n = 0; n < 7; n++) rd_exp("ovf_rd_b0", 8'(n));
        cyc(1'b1, 1'b1, 8'd50, 8'd0);
        $display("[TB] collide: rd=%0d cnt=%0d full=%0b", o_rd[7:0], o_bank_cnt, o_full);
        chk("coll_rd",   {24'd0, o_rd[7:0]},  32'd7);
        chk("coll_cnt",  {30'd0, o_bank_cnt}, 32'd1);
        chk("coll_full", {31'd0, o_full},     32'd0);
        wr(8'd51);
        chk("retry_cnt", {30'd0, o_bank_cnt}, 32'd1);
        for (int n = 8; n < 16; n++) rd_exp("ovf_rd_b1", 8'(n));
        chk("drain_cnt", {30'd0, o_bank_cnt}, 32'd0);
        chk("drain_ne",  {31'd0, o_nempty},   32'd0);
        for (int n = 52; n < 59; n++) wr(8'(n));
        chk("refill_cnt", {30'd0, o_bank_cnt}, 32'd1);
        for (int n = 51; n < 59; n++) rd_exp("retry_rd", 8'(n));
        cyc(1'b0, 1'b1, 8'd0, 8'd0);
        $display("[TB] underflow read: vld=%0b err=%0b", o_rd_valid, o_err);
        chk("udf_vld", {31'd0, o_rd_valid}, 32'd0);
        chk("udf_err", {31'd0, o_err},      {31'd0, ERR_EN});

        // Simultaneous fill of bank 1 and free of bank 0.
        do_reset();
        for (int n = 0; n < 8; n++) wr(8'(n));
        for (int n = 10; n < 17; n++) wr(8'(n));
        chk("sim_pre_cnt", {30'd0, o_bank_cnt}, 32'd1);
        for (int n = 0; n < 7; n++) rd_exp("sim_rd_b0", 8'(n));
        cyc(1'b1, 1'b1, 8'd17, 8'd0);
        $display("[TB] fill+free: rd=%0d cnt=%0d", o_rd[7:0], o_bank_cnt);
        chk("sim_rd",   {24'd0, o_rd[7:0]},  32'd7);
        chk("sim_cnt",  {30'd0, o_bank_cnt}, 32'd1);
        chk("sim_full", {31'd0, o_full},     32'd0);
        chk("sim_ne",   {31'd0, o_nempty},   32'd1);
        for (int n = 10; n < 18; n++) rd_exp("sim_rd_b1", 8'(n));
        chk("sim_end_cnt", {30'd0, o_bank_cnt}, 32'd0);

        // Reset mid-line discards everything; writes blocked until reset release is synchronised.
        do_reset();
        for (int n = 30; n < 38; n++) wr(8'(n));
        rd_exp("pre_rst_rd", 8'd30);
        for (int n = 40; n < 45; n++) wr(8'(n));
        i_arstn = 1'b0;
        #2;
        $display("[TB] async reset: cnt=%0d ne=%0b rd=%04h", o_bank_cnt, o_nempty, o_rd);
        chk("mid_rst_cnt",  {30'd0, o_bank_cnt}, 32'd0);
        chk("mid_rst_ne",   {31'd0, o_nempty},   32'd0);
        chk("mid_rst_full", {31'd0, o_full},     32'd0);
        chk("mid_rst_vld",  {31'd0, o_rd_valid}, 32'd0);
        chk("mid_rst_rd",   {16'd0, o_rd},       32'd0);
        chk("mid_rst_err",  {31'd0, o_err},      32'd0);
        @(posedge i_sysclk);
        #1;
        i_arstn = 1'b1;
        wr(8'd77);
        cyc(1'b0, 1'b0, 8'd0, 8'd0);
        for (int n = 20; n < 28; n++) wr(8'(n));
        chk("post_rst_cnt", {30'd0, o_bank_cnt}, 32'd1);
        for (int n = 20; n < 28; n++) rd_exp("post_rst_rd", 8'(n));

        // Width change mid-bank applies only from the next bank.
        i_hres = XW'(3);
        wr(8'd0);
        wr(8'd1);
        i_hres = XW'(1);
        for (int n = 2; n < 8; n++) wr(8'(n));
        chk("hres_b0_cnt", {30'd0, o_bank_cnt}, 32'd1);
        for (int n = 8; n < 11; n++) wr(8'(n));
        chk("hres_b1_part", {30'd0, o_bank_cnt}, 32'd1);
        wr(8'd11);
        $display("[TB] narrow bank filled: cnt=%0d full=%0b", o_bank_cnt, o_full);
        chk("hres_b1_cnt",  {30'd0, o_bank_cnt}, 32'd2);
        chk("hres_b1_full", {31'd0, o_full},     32'd1);
        i_hres = XW'(3);
        for (int n = 0; n < 8; n++) rd_exp("hres_rd_wide", 8'(n));
        chk("hres_rd_cnt1", {30'd0, o_bank_cnt}, 32'd1);
        i_hres = XW'(1);
        for (int n = 8; n < 12; n++) rd_exp("hres_rd_narrow", 8'(n));
        chk("hres_rd_cnt0", {30'd0, o_bank_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/line_buffer_pp.md
LINE_BUFFER_PP -- requirements
Module: line_buffer_pp

Interface
REQ-001 SHALL have parameter COLOR_PRECISION, default 8: bits per colour sample.
REQ-002 SHALL have parameter MAX_HRES, default 480: maximum pixels per line; X counter width XW = ceil(log2(MAX_HRES)).
REQ-003 SHALL have parameter LINE, default 16, power of two: lines per bank.
REQ-004 SHALL have parameter NUM_CH, default 3, range 1..4: channel count; ch0 is luma, ch1..NUM_CH-1 are chroma.
REQ-005 SHALL have parameter NUM_BANK, default 2, power of two, range 2..4: ping-pong bank count.
REQ-006 SHALL have parameters C_XO_SUBSAMPLE and C_YO_SUBSAMPLE, each 1 or 2, defaults 2 and 2: chroma storage decimation.
REQ-007 i_sysclk  in  1  sole clock; all logic on its rising edge.
REQ-008 i_arstn  in  1  asynchronous, active-low reset.
REQ-009 i_hres  in  XW  last pixel index of a line (active width minus 1); sampled at the start of every bank fill and every bank drain.
REQ-010 i_we  in  1  write strobe for one pixel.
REQ-011 i_wd  in  NUM_CH*COLOR_PRECISION  packed pixel; ch0 occupies the LSBs.
REQ-012 o_full  out  1  all banks filled.
REQ-013 i_re  in  1  read strobe for one pixel.
REQ-014 o_rd  out  NUM_CH*COLOR_PRECISION  packed read pixel, same packing as i_wd.
REQ-015 o_rd_valid  out  1  o_rd valid this cycle.
REQ-016 o_nempty  out  1  at least one complete bank is readable.
REQ-017 o_bank_cnt  out  ceil(log2(NUM_BANK+1))  number of filled, unread banks.
REQ-018 o_err  out  1  sticky error flag (see REQ-033).

Function
REQ-019 Write pointer SHALL be {wbank, wy, wx}; raster order; advance only on i_we & ~o_full.
REQ-020 On accepted write: wx SHALL increment; when wx == latched hres: wx -> 0 and wy increments; when wy == LINE-1 as well: wy -> 0, wbank increments modulo NUM_BANK, and the bank counts as filled.
REQ-021 Read pointer {rbank, ry, rx} SHALL advance identically on i_re & o_nempty; completing ry == LINE-1 with rx == latched hres SHALL free the bank.
REQ-022 ch0 SHALL be stored at every (x,y); chroma SHALL be written only when wx mod C_XO_SUBSAMPLE == 0 and wy mod C_YO_SUBSAMPLE == 0, at address {bank, y>>(C_YO_SUBSAMPLE-1), x>>(C_XO_SUBSAMPLE-1)}.
REQ-023 Chroma reads SHALL use the same decimated address, replicating each stored chroma sample across its 2x / 2x2 neighbourhood.
REQ-024 Read latency SHALL be exactly 1 cycle: o_rd_valid = registered (i_re & o_nempty); o_rd holds its value when o_rd_valid is low.
REQ-025 o_bank_cnt SHALL +1 on a bank fill, -1 on a bank free, and remain unchanged when both occur in the same cycle.
REQ-026 o_full SHALL equal (o_bank_cnt == NUM_BANK); o_nempty SHALL equal (o_bank_cnt != 0); both registered.
REQ-027 A read SHALL never access the bank currently being written; a write issued in the same cycle as the freeing read of the last full bank SHALL be rejected and a retry SHALL be accepted in the next cycle.
REQ-028 Changing i_hres mid-bank SHALL NOT affect the bank in progress.
REQ-029 Storage SHALL be NUM_CH simple dual-port RAMs without output register; total depth NUM_BANK*LINE*2^XW for luma, divided by C_XO_SUBSAMPLE*C_YO_SUBSAMPLE for chroma.

Reset
REQ-030 Assertion of i_arstn low SHALL immediately clear all pointers, o_bank_cnt, o_full, o_nempty, o_rd_valid and o_err to 0; o_rd SHALL be 0.
REQ-031 Reset asserted mid-line SHALL discard all buffered data; RAM contents need not be cleared.
REQ-032 Release of reset SHALL be synchronised internally; the first write is accepted no earlier than 2 cycles after release.

Configuration
REQ-033 With LINE_BUFFER_PP_ERR_EN defined, o_err SHALL set on i_we & o_full (overflow) or i_re & ~o_nempty (underflow), and clear only on reset; without the macro, o_err SHALL be constant 0 and no detection logic SHALL exist.

Verification
REQ-034 LINE=2, NUM_BANK=2, i_hres=3, write 8 pixels 0..7 -> o_bank_cnt=1, o_nempty=1 after the 8th write; 8 reads return 0..7, each 1 cycle after i_re.
REQ-035 Write 16 pixels with no reads -> o_full=1; a 17th write is ignored; with ERR_EN, o_err=1.
REQ-036 Bank full with bank 1 filling: read the final pixel of bank 0 and write the final pixel of bank 1 in the same cycle -> o_bank_cnt stays 1.
REQ-037 C_XO=C_YO=2, ch1 written as x+10*y -> reads at (1,1) and (0,1) both return ch1=0.
REQ-038 Reset asserted after 5 writes -> all flags 0; next 8 writes fill bank 0 from address 0.
REQ-039 i_hres changed from 3 to 1 mid-bank -> current bank keeps 4-pixel lines; the next bank uses 2-pixel lines.
